// File: rtl/compare_pkg.sv
// Shared types and helpers for the serial magnitude comparator.
package compare_pkg;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  // One-hot result encoding, bit order {gt, eq, lt}.
  localparam logic [2:0] RES_GT = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_LT = 3'b001;

  function automatic int unsigned ndig(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

  // Wide enough to hold the value NDIG itself.
  function automatic int unsigned cnt_width(input int unsigned width, input int unsigned digit);
    return $clog2(width / digit) + 1;
  endfunction

  function automatic int unsigned idx_width(input int unsigned width, input int unsigned digit);
    return (width / digit > 1) ? $clog2(width / digit) : 1;
  endfunction

endpackage

// File: rtl/compare_serial_if.sv
// Operand and result handshakes of the serial comparator.
interface compare_serial_if
  import compare_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) ();

  localparam int unsigned CntW = cnt_width(WIDTH, DIGIT);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic             gt;
  logic             eq;
  logic             lt;
  logic [CntW-1:0]  digits_used;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, gt, eq, lt, digits_used
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, gt, eq, lt, digits_used
  );

endinterface

// File: rtl/compare_digit.sv
// Combinational unsigned comparison of one DIGIT-bit slice.
module compare_digit #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  output logic             gt_o,
  output logic             eq_o,
  output logic             lt_o
);

  assign gt_o = (a_i > b_i);
  assign eq_o = (a_i == b_i);
  assign lt_o = (a_i < b_i);

endmodule

// File: rtl/compare_serial.sv
// Multi-cycle MSB-first magnitude comparator with early termination and
// registered one-hot result.
module compare_serial
  import compare_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIGIT     = 2,
  parameter bit          SIGNED_EN = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  compare_serial_if.slave bus
);

  localparam int unsigned NDIG = ndig(WIDTH, DIGIT);
  localparam int unsigned CntW = cnt_width(WIDTH, DIGIT);
  localparam int unsigned IdxW = idx_width(WIDTH, DIGIT);
  localparam logic [WIDTH-1:0] MsbMask = WIDTH'(1) << (WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IdxW-1:0]  idx_q;
  logic [CntW-1:0]  cnt_q;
  logic [2:0]       res_q;
  logic             out_valid_q;

  logic [WIDTH-1:0] flip_mask;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic             dig_gt;
  logic             dig_eq;
  logic             dig_lt;

  // Flipping both MSBs maps two's complement onto offset binary, so the
  // unsigned digit scan yields the signed ordering.
  assign flip_mask = (SIGNED_EN && bus.signed_mode) ? MsbMask : '0;

  assign a_dig = a_q[int'(idx_q) * DIGIT +: DIGIT];
  assign b_dig = b_q[int'(idx_q) * DIGIT +: DIGIT];

  compare_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a_i  (a_dig),
    .b_i  (b_dig),
    .gt_o (dig_gt),
    .eq_o (dig_eq),
    .lt_o (dig_lt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            a_q     <= bus.a ^ flip_mask;
            b_q     <= bus.b ^ flip_mask;
            idx_q   <= IdxW'(NDIG - 1);
            cnt_q   <= '0;
            state_q <= StScan;
          end
        end
        StScan: begin
          cnt_q <= cnt_q + CntW'(1);
          if (dig_gt) begin
            res_q       <= RES_GT;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else if (dig_lt) begin
            res_q       <= RES_LT;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else if (dig_eq && idx_q == '0) begin
            res_q       <= RES_EQ;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            idx_q <= idx_q - IdxW'(1);
          end
        end
        StDone: begin
          // digits_used is left untouched until the next accept.
          if (bus.out_ready) begin
            res_q       <= '0;
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready    = (state_q == StIdle);
  assign bus.out_valid   = out_valid_q;
  assign bus.gt          = res_q[2];
  assign bus.eq          = res_q[1];
  assign bus.lt          = res_q[0];
  assign bus.digits_used = cnt_q;

endmodule

// File: tb/tb_compare_serial.sv
// Self-checking bench for compare_serial across several WIDTH/DIGIT/SIGNED_EN builds.
module tb_compare_serial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  compare_serial_if #(.WIDTH(8),  .DIGIT(2)) bus0 ();
  compare_serial_if #(.WIDTH(8),  .DIGIT(2)) bus1 ();
  compare_serial_if #(.WIDTH(16), .DIGIT(4)) bus2 ();
  compare_serial_if #(.WIDTH(4),  .DIGIT(1)) bus3 ();
  compare_serial_if #(.WIDTH(8),  .DIGIT(8)) bus4 ();

  compare_serial #(.WIDTH(8),  .DIGIT(2), .SIGNED_EN(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  compare_serial #(.WIDTH(8),  .DIGIT(2), .SIGNED_EN(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  compare_serial #(.WIDTH(16), .DIGIT(4), .SIGNED_EN(1'b1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  compare_serial #(.WIDTH(4),  .DIGIT(1), .SIGNED_EN(1'b1)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));
  compare_serial #(.WIDTH(8),  .DIGIT(8), .SIGNED_EN(1'b1)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: integer comparison of the operands as plain numbers.
  function automatic logic [2:0] ref_res(input logic [15:0] av, input logic [15:0] bv,
                                         input int w, input bit sgn);
    longint sa = longint'(av);
    longint sb = longint'(bv);
    if (sgn && av[w-1]) sa -= (longint'(1) << w);
    if (sgn && bv[w-1]) sb -= (longint'(1) << w);
    if (sa > sb) return 3'b100;
    if (sa < sb) return 3'b001;
    return 3'b010;
  endfunction

  // Reference: digits examined = digits down to and including the one holding
  // the highest differing bit, or all digits when equal.
  function automatic int ref_du(input logic [15:0] av, input logic [15:0] bv,
                                input int w, input int d);
    logic [15:0] x = av ^ bv;
    int p = -1;
    for (int i = 0; i < w; i++) if (x[i]) p = i;
    if (p < 0) return w / d;
    return w / d - p / d;
  endfunction

  task automatic op0(input logic [7:0] av, input logic [7:0] bv, input bit sm, input bit early);
    int n = 0;
    int lat = 0;
    while (!bus0.in_ready && n < 20) begin tick(); n++; end
    chk("op_in_ready", bus0.in_ready, 1);
    bus0.a = av; bus0.b = bv; bus0.signed_mode = sm;
    bus0.in_valid = 1'b1; bus0.out_ready = early;
    tick();
    bus0.in_valid = 1'b0;
    bus0.a = 8'($urandom); bus0.b = 8'($urandom); bus0.signed_mode = 1'($urandom);
    chk("busy_in_ready", bus0.in_ready, 0);
    while (!bus0.out_valid && lat < 16) begin tick(); lat++; end
    chk("latency", lat, ref_du({8'h0, av}, {8'h0, bv}, 8, 2));
    chk("result", {bus0.gt, bus0.eq, bus0.lt}, ref_res({8'h0, av}, {8'h0, bv}, 8, sm));
    chk("digits_used", bus0.digits_used, ref_du({8'h0, av}, {8'h0, bv}, 8, 2));
    bus0.out_ready = 1'b1;
    tick();
    bus0.out_ready = 1'b0;
    chk("after_xfer", {bus0.out_valid, bus0.gt, bus0.eq, bus0.lt}, 0);
  endtask

`define SEC_OP(IFC, TAG, W, D, SGN, AV, BV, SM) \
  begin \
    IFC.a = AV[W-1:0]; IFC.b = BV[W-1:0]; IFC.signed_mode = SM; IFC.in_valid = 1'b1; \
    tick(); \
    IFC.in_valid = 1'b0; lat = 0; \
    while (!IFC.out_valid && lat < 32) begin tick(); lat++; end \
    chk({TAG, "_lat"}, lat, ref_du(AV, BV, W, D)); \
    chk({TAG, "_res"}, {IFC.gt, IFC.eq, IFC.lt}, ref_res(AV, BV, W, SGN)); \
    chk({TAG, "_du"}, IFC.digits_used, ref_du(AV, BV, W, D)); \
    IFC.out_ready = 1'b1; tick(); IFC.out_ready = 1'b0; \
  end

  initial begin
    int lat;
    logic [15:0] av, bv;
    bit sm;

    bus0.in_valid = 0; bus0.a = 0; bus0.b = 0; bus0.signed_mode = 0; bus0.out_ready = 0;
    bus1.in_valid = 0; bus1.a = 0; bus1.b = 0; bus1.signed_mode = 0; bus1.out_ready = 0;
    bus2.in_valid = 0; bus2.a = 0; bus2.b = 0; bus2.signed_mode = 0; bus2.out_ready = 0;
    bus3.in_valid = 0; bus3.a = 0; bus3.b = 0; bus3.signed_mode = 0; bus3.out_ready = 0;
    bus4.in_valid = 0; bus4.a = 0; bus4.b = 0; bus4.signed_mode = 0; bus4.out_ready = 0;

    // Reset state
    tick(); tick();
    chk("rst_outputs", {bus0.out_valid, bus0.gt, bus0.eq, bus0.lt}, 0);
    chk("rst_du", bus0.digits_used, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", bus0.in_ready, 1);
    chk("rst_in_ready16", bus2.in_ready, 1);

    // Directed: early GT, full-length EQ and GT
    op0(8'hA5, 8'h35, 1'b0, 1'b0);
    op0(8'h5A, 8'h5A, 1'b0, 1'b0);
    op0(8'h5B, 8'h5A, 1'b0, 1'b0);

    // Signed versus unsigned
    op0(8'h80, 8'h01, 1'b1, 1'b0);
    op0(8'h80, 8'h01, 1'b0, 1'b0);
    av = 16'h0080; bv = 16'h0001;
    `SEC_OP(bus1, "nosigned", 8, 2, 1'b0, av, bv, 1'b1)

    // Backpressure with an ignored in_valid while DONE
    bus0.a = 8'h01; bus0.b = 8'h02; bus0.signed_mode = 1'b0; bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    lat = 0;
    while (!bus0.out_valid && lat < 16) begin tick(); lat++; end
    chk("bp_lat", lat, 4);
    chk("bp_res", {bus0.gt, bus0.eq, bus0.lt}, 3'b001);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin bus0.a = 8'hFF; bus0.b = 8'h00; bus0.in_valid = 1'b1; end
      tick();
      bus0.in_valid = 1'b0;
      chk("bp_valid", bus0.out_valid, 1);
      chk("bp_hold_res", {bus0.gt, bus0.eq, bus0.lt}, 3'b001);
      chk("bp_hold_du", bus0.digits_used, 4);
      chk("bp_in_ready", bus0.in_ready, 0);
    end
    // in_valid on the completing cycle must wait for the next IDLE cycle
    bus0.out_ready = 1'b1; bus0.in_valid = 1'b1; bus0.a = 8'h7F; bus0.b = 8'h00;
    tick();
    bus0.out_ready = 1'b0;
    chk("bp_xfer_clear", {bus0.out_valid, bus0.gt, bus0.eq, bus0.lt}, 0);
    chk("bp_idle_ready", bus0.in_ready, 1);
    tick();
    bus0.in_valid = 1'b0;
    chk("late_accept", bus0.in_ready, 0);
    lat = 0;
    while (!bus0.out_valid && lat < 16) begin tick(); lat++; end
    chk("late_lat", lat, 1);
    chk("late_res", {bus0.gt, bus0.eq, bus0.lt}, 3'b100);
    chk("late_du", bus0.digits_used, 1);
    bus0.out_ready = 1'b1; tick(); bus0.out_ready = 1'b0;

    // Reset mid-scan aborts without a result
    bus0.a = 8'h01; bus0.b = 8'h00; bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_out", {bus0.out_valid, bus0.gt, bus0.eq, bus0.lt}, 0);
    chk("midrst_du", bus0.digits_used, 0);
    chk("midrst_ready", bus0.in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst_no_result", bus0.out_valid, 0);
    end
    op0(8'h03, 8'h03, 1'b0, 1'b0);

    // out_ready already high while the scan resolves
    op0(8'h40, 8'h41, 1'b0, 1'b1);

    // Other parametrisations
    av = 16'h1234; bv = 16'h1235;
    `SEC_OP(bus2, "w16d4", 16, 4, 1'b0, av, bv, 1'b0)
    av = 16'h0008; bv = 16'h0007;
    `SEC_OP(bus3, "w4d1", 4, 1, 1'b0, av, bv, 1'b0)
    av = 16'h0010; bv = 16'h0010;
    `SEC_OP(bus4, "w8d8", 8, 8, 1'b0, av, bv, 1'b0)

    // Random operands, biased toward long common prefixes
    for (int i = 0; i < 40; i++) begin
      av = 16'($urandom);
      case ($urandom_range(0, 2))
        0: bv = av;
        1: bv = av ^ (16'h1 << $urandom_range(0, 15));
        default: bv = 16'($urandom);
      endcase
      sm = 1'($urandom);
      op0(av[7:0], bv[7:0], sm, 1'($urandom));
    end
    for (int i = 0; i < 12; i++) begin
      av = 16'($urandom);
      bv = ($urandom_range(0, 1) == 0) ? (av ^ (16'h1 << $urandom_range(0, 15))) : 16'($urandom);
      sm = 1'($urandom);
      `SEC_OP(bus2, "rnd16", 16, 4, sm, av, bv, sm)
      av = {12'h0, 4'($urandom)};
      bv = {12'h0, 4'($urandom)};
      `SEC_OP(bus3, "rnd4", 4, 1, sm, av, bv, sm)
      av = {8'h0, 8'($urandom)};
      bv = {8'h0, 8'($urandom)};
      `SEC_OP(bus4, "rnd8d8", 8, 8, sm, av, bv, sm)
      `SEC_OP(bus1, "rndns", 8, 2, 1'b0, av, bv, sm)
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

`undef SEC_OP

endmodule
